// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit. It fetches one word per instruction from
// instruction memory and hands it to the control unit. It tracks the PC,
// re-issues a read that times out, and records each timeout in a sticky
// error flag.
module instr_fetch_unit #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [7:0]        imem_addr,
    output logic              imem_rd,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              imem_valid,
    input  logic              cu_done,
    input  logic              pc_load,
    input  logic [15:0]       pc_din,
    output logic [15:0]       pc_value,
    output logic [DATA_W-1:0] instr,
    output logic              new_instr,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_EXEC  = 3'd4
    } state_t;

    // The counter holds 14 on the 15th silent WAIT cycle, so that cycle
    // takes the counter to 15 and triggers the re-issue.
    localparam logic [3:0] WAIT_LAST = 4'd14;

    state_t             state;
    state_t             state_next;
    logic [15:0]        pc;
    logic [3:0]         wait_cnt;
    logic               load_instr;
    logic               inc_pc;
    logic               load_pc;
    logic               clr_cnt;
    logic               inc_cnt;
    logic               set_err;

    assign imem_addr = pc[7:0];
    assign pc_value  = pc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, strobes and datapath enables
    always_comb begin
        state_next = state;
        imem_rd    = 1'b0;
        new_instr  = 1'b0;
        load_instr = 1'b0;
        inc_pc     = 1'b0;
        load_pc    = 1'b0;
        clr_cnt    = 1'b0;
        inc_cnt    = 1'b0;
        set_err    = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                imem_rd    = 1'b1;
                clr_cnt    = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_valid) begin
                    load_instr = 1'b1;
                    state_next = S_ISSUE;
                end else begin
                    inc_cnt = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        set_err    = 1'b1;
                        state_next = S_REQ;
                    end
                end
            end
            S_ISSUE: begin
                new_instr  = 1'b1;
                inc_pc     = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                load_pc = pc_load;
                if (cu_done) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // PC register: increments after issue and takes a branch target only in EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= 16'h0000;
        end else if (load_pc) begin
            pc <= pc_din;
        end else if (inc_pc) begin
            pc <= pc + 16'h0001;
        end
    end

    // Instruction register: captures data only when a WAIT cycle accepts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= '0;
        end else if (load_instr) begin
            instr <= imem_data;
        end
    end

    // Wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= 4'd0;
            fetch_err <= 1'b0;
        end else begin
            if (clr_cnt) begin
                wait_cnt <= 4'd0;
            end else if (inc_cnt) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (set_err) begin
                fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit. Expected values are hand-derived
// cycle by cycle. Inputs change 1 time unit after each rising edge, and
// outputs are sampled at the same point.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        cu_done;
    logic        pc_load;
    logic [15:0] pc_din;
    logic [15:0] pc_value;
    logic [15:0] instr;
    logic        new_instr;
    logic        fetch_err;

    int n_vec;
    int n_err;

    instr_fetch_unit #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .cu_done    (cu_done),
        .pc_load    (pc_load),
        .pc_din     (pc_din),
        .pc_value   (pc_value),
        .instr      (instr),
        .new_instr  (new_instr),
        .fetch_err  (fetch_err)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it miscompares
    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        imem_data  = 16'h0000;
        imem_valid = 1'b0;
        cu_done    = 1'b0;
        pc_load    = 1'b0;
        pc_din     = 16'h0000;

        // Reset values
        step();
        step();
        check_vec("rst_rd",    {15'd0, imem_rd},   16'h0000);
        check_vec("rst_pc",    pc_value,           16'h0000);
        check_vec("rst_instr", instr,              16'h0000);
        check_vec("rst_new",   {15'd0, new_instr}, 16'h0000);
        check_vec("rst_err",   {15'd0, fetch_err}, 16'h0000);
        rst = 1'b0;

        // First fetch: IDLE then REQ at address 0, latency 1
        step();
        check_vec("f0_rd",   {15'd0, imem_rd}, 16'h0001);
        check_vec("f0_addr", {8'd0, imem_addr}, 16'h0000);
        step();
        check_vec("f0_wait_rd", {15'd0, imem_rd}, 16'h0000);
        imem_valid = 1'b1;
        imem_data  = 16'h02FF;
        step();
        imem_valid = 1'b0;
        check_vec("f0_new",   {15'd0, new_instr}, 16'h0001);
        check_vec("f0_instr", instr,              16'h02FF);
        step();
        check_vec("f0_exec_new", {15'd0, new_instr}, 16'h0000);
        check_vec("f0_exec_pc",  pc_value,           16'h0001);
        step();
        cu_done = 1'b1;
        step();
        cu_done = 1'b0;
        check_vec("f1_rd",   {15'd0, imem_rd}, 16'h0001);
        check_vec("f1_addr", {8'd0, imem_addr}, 16'h0001);

        // Branch: pc_load and cu_done in the same EXEC cycle
        step();
        imem_valid = 1'b1;
        imem_data  = 16'h6700;
        step();
        imem_valid = 1'b0;
        check_vec("f1_instr", instr, 16'h6700);
        step();
        check_vec("f1_exec_pc", pc_value, 16'h0002);
        pc_load = 1'b1;
        pc_din  = 16'h0040;
        cu_done = 1'b1;
        step();
        pc_load = 1'b0;
        cu_done = 1'b0;
        check_vec("br_pc",   pc_value,           16'h0040);
        check_vec("br_rd",   {15'd0, imem_rd},   16'h0001);
        check_vec("br_addr", {8'd0, imem_addr},  16'h0040);

        // Timeout: 15 silent WAIT cycles, then re-issue at the same address
        for (int i = 0; i < 15; i++) begin
            step();
            check_vec($sformatf("to_wait%0d_rd", i), {15'd0, imem_rd}, 16'h0000);
            check_vec($sformatf("to_wait%0d_err", i), {15'd0, fetch_err}, 16'h0000);
        end
        step();
        check_vec("to_rd",   {15'd0, imem_rd},   16'h0001);
        check_vec("to_addr", {8'd0, imem_addr},  16'h0040);
        check_vec("to_err",  {15'd0, fetch_err}, 16'h0001);
        step();
        imem_valid = 1'b1;
        imem_data  = 16'h1234;
        step();
        imem_valid = 1'b0;
        check_vec("to_new",      {15'd0, new_instr}, 16'h0001);
        check_vec("to_instr",    instr,              16'h1234);
        check_vec("to_err_hold", {15'd0, fetch_err}, 16'h0001);
        step();
        check_vec("to_exec_pc", pc_value, 16'h0041);

        // A stray valid in EXEC is ignored; pc_load in EXEC loads 0xFFFF
        imem_valid = 1'b1;
        imem_data  = 16'hDEAD;
        pc_load    = 1'b1;
        pc_din     = 16'hFFFF;
        step();
        imem_valid = 1'b0;
        pc_load    = 1'b0;
        check_vec("stray_instr", instr,              16'h1234);
        check_vec("stray_new",   {15'd0, new_instr}, 16'h0000);
        check_vec("exec_ld_pc",  pc_value,           16'hFFFF);
        cu_done = 1'b1;
        step();
        cu_done = 1'b0;
        check_vec("ff_rd",   {15'd0, imem_rd},  16'h0001);
        check_vec("ff_addr", {8'd0, imem_addr}, 16'h00FF);
        step();
        // pc_load in WAIT is ignored
        pc_load = 1'b1;
        pc_din  = 16'h0100;
        step();
        pc_load = 1'b0;
        check_vec("wait_ld_pc", pc_value, 16'hFFFF);
        imem_valid = 1'b1;
        imem_data  = 16'hBEEF;
        step();
        imem_valid = 1'b0;
        check_vec("ff_instr", instr, 16'hBEEF);
        step();
        check_vec("wrap_pc", pc_value, 16'h0000);

        // Reset during WAIT with a late valid
        cu_done = 1'b1;
        step();
        cu_done = 1'b0;
        check_vec("pre_rst_rd", {15'd0, imem_rd}, 16'h0001);
        step();
        rst = 1'b1;
        #2;
        check_vec("arst_instr", instr,              16'h0000);
        check_vec("arst_err",   {15'd0, fetch_err}, 16'h0000);
        check_vec("arst_rd",    {15'd0, imem_rd},   16'h0000);
        check_vec("arst_pc",    pc_value,           16'h0000);
        #1;
        rst        = 1'b0;
        imem_valid = 1'b1;
        imem_data  = 16'h5555;
        step();
        imem_valid = 1'b0;
        check_vec("late_instr", instr,              16'h0000);
        check_vec("late_new",   {15'd0, new_instr}, 16'h0000);
        check_vec("re_rd",      {15'd0, imem_rd},   16'h0001);
        check_vec("re_addr",    {8'd0, imem_addr},  16'h0000);
        step();
        imem_valid = 1'b1;
        imem_data  = 16'h0AAA;
        step();
        imem_valid = 1'b0;
        check_vec("re_new",   {15'd0, new_instr}, 16'h0001);
        check_vec("re_instr", instr,              16'h0AAA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 imem_addr  out  8  instruction memory word address, equal to pc[7:0].
REQ-004 imem_rd  out  1  one-cycle read request strobe to instruction memory.
REQ-005 imem_data  in  16  instruction word from memory, sampled only when imem_valid=1.
REQ-006 imem_valid  in  1  read data valid; earliest 1 cycle after imem_rd, arbitrary latency.
REQ-007 cu_done  in  1  control unit has finished the current instruction.
REQ-008 pc_load  in  1  control unit request to overwrite PC from bus (branch/ldpc).
REQ-009 pc_din  in  16  new PC value, sampled when pc_load=1.
REQ-010 pc_value  out  16  current PC, driven continuously for control unit pcout.
REQ-011 instr  out  16  instruction register feeding control unit instr.
REQ-012 new_instr  out  1  one-cycle pulse: instr holds a freshly fetched word.
REQ-013 fetch_err  out  1  sticky flag: at least one fetch timed out.

Function
REQ-014 The block SHALL implement FSM states IDLE, REQ, WAIT, ISSUE, EXEC.
REQ-015 IDLE SHALL last exactly one cycle, then transition to REQ.
REQ-016 REQ SHALL assert imem_rd=1 for exactly one cycle with imem_addr=pc[7:0], then transition to WAIT.
REQ-017 WAIT SHALL hold imem_rd=0; on imem_valid=1 it SHALL latch imem_data into instr and transition to ISSUE.
REQ-018 A 4-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without imem_valid.
REQ-019 When the counter reaches 15 without imem_valid, the FSM SHALL return to REQ (re-issue same address) and set fetch_err=1.
REQ-020 fetch_err SHALL be cleared only by rst.
REQ-021 imem_valid outside WAIT SHALL be ignored (no instr update, no state change).
REQ-022 ISSUE SHALL last one cycle, drive new_instr=1, increment pc by 1 (16-bit, 0xFFFF wraps to 0x0000), then go to EXEC.
REQ-023 new_instr SHALL be 0 in every state except ISSUE.
REQ-024 instr SHALL remain stable from ISSUE until the next imem_valid accepted in WAIT.
REQ-025 In EXEC, pc_load=1 SHALL set pc<=pc_din; pc_load in any other state SHALL be ignored.
REQ-026 In EXEC, cu_done=1 SHALL transition to REQ next cycle; cu_done in other states SHALL be ignored.
REQ-027 pc_load and cu_done together in EXEC SHALL load pc_din and go to REQ, so the next fetch uses pc_din[7:0].
REQ-028 pc_value SHALL equal the pc register at all times; during EXEC it is the address after the executing instruction unless overwritten.
REQ-029 Fetch-to-issue latency SHALL be memory latency + 1 cycle (REQ edge to ISSUE).

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, pc=0x0000, instr=0x0000, new_instr=0, imem_rd=0, fetch_err=0, wait counter=0.
REQ-031 Reset asserted mid-fetch or mid-EXEC SHALL abort the operation; a late imem_valid after reset SHALL be ignored.
REQ-032 After rst deasserts, the first imem_rd SHALL occur in the second cycle (IDLE then REQ) with imem_addr=0x00.

Verification
REQ-033 Memory [0]=0x02FF, latency 1, cu_done 2 cycles after new_instr -> imem_rd at addr 0, instr=0x02FF, new_instr one pulse, pc_value=0x0001 in EXEC, next imem_rd at addr 0x01.
REQ-034 Memory [1]=0x6700 with pc_load=1, pc_din=0x0040, cu_done=1 same EXEC cycle -> pc_value=0x0040, next imem_rd at addr 0x40.
REQ-035 Memory silent for 15 WAIT cycles -> imem_rd re-issued at same addr, fetch_err=1 and stays 1; data then returned -> normal ISSUE.
REQ-036 pc_din=0xFFFF loaded, fetch completes -> imem_addr=0xFF, pc_value=0x0000 after ISSUE.
REQ-037 rst pulsed during WAIT, imem_valid arrives next cycle -> instr stays 0x0000, no new_instr, fetch restarts at addr 0x00.
REQ-038 imem_valid pulsed and pc_load=1 during EXEC without cu_done, then pc_load=1 in WAIT -> instr unchanged by stray valid, PC changed only by EXEC load.
